descriptor_sum_scheduler: RTL

Shares the single 4-stage descriptor summation pipeline (128 x 13-bit elements to a 20-bit sum) between NUM_REQ descriptor generators.
- Arbitrates requesters round-robin, issues at most one descriptor per cycle into the adder, and tags each issue with its requester ID.
- Re-associates returning sums with their tags and buffers {id, sum, zero} results in a credit-protected output FIFO.
- Sits between the descriptor generators and the normalization stage.

---
 rtl/descriptor_sum_scheduler_pkg.sv | 21 ++
 rtl/sum_result_fifo.sv | 70 +++++++
 rtl/descriptor_sum_scheduler.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/descriptor_sum_scheduler_pkg.sv
// Purpose : shared SIFT descriptor parameters and result-record widths for the sum scheduler.
// Latency : n/a (constants and helpers only).
// Backpr. : n/a.
package descriptor_sum_scheduler_pkg;

    localparam int DESC_ELEMS  = 128;
    localparam int DESC_BITS   = 13;
    localparam int SUM_W       = 20;
    localparam int ADD_LATENCY = 4;

    localparam int SIFTDescriptor_output_bits = DESC_ELEMS * DESC_BITS;

    // Result record is {id, sum, zero}; id width depends on the requester count.
    localparam int RES_SUM_W  = SUM_W;
    localparam int RES_ZERO_W = 1;

    function automatic int res_rec_w(input int id_w);
        return id_w + RES_SUM_W + RES_ZERO_W;
    endfunction

endpackage

// File: rtl/sum_result_fifo.sv
// Purpose : synchronous FIFO with occupancy count; head entry is read straight from storage flops.
// Latency : a push into an empty FIFO is visible on odata/oempty the following cycle (no bypass).
// Backpr. : none internally; a push while full without a same-cycle pop is dropped (callers use credits).
// Ports   : iclk/ireset (async active-low), ipush/idata write side, ipop read side,
//           odata head entry, oempty, ocount occupancy 0..DEPTH.
module sum_result_fifo #(
    parameter int WIDTH = 22,
    parameter int DEPTH = 8
) (
    input  logic                     iclk,
    input  logic                     ireset,
    input  logic                     ipush,
    input  logic [WIDTH-1:0]         idata,
    input  logic                     ipop,
    output logic [WIDTH-1:0]         odata,
    output logic                     oempty,
    output logic [$clog2(DEPTH):0]   ocount
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    always_comb begin
        do_pop   = ipop && (count_q != '0);
        do_push  = ipush && ((count_q != (AW+1)'(DEPTH)) || do_pop);
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = idata;
            wr_ptr_d        = wr_ptr_q + 1'b1;   // DEPTH is a power of 2: natural wrap
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (do_push && !do_pop) begin
            count_d = count_q + 1'b1;
        end else if (do_pop && !do_push) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge iclk or negedge ireset) begin
        if (!ireset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign odata  = mem_q[rd_ptr_q];
    assign oempty = (count_q == '0);
    assign ocount = count_q;

endmodule

// File: rtl/descriptor_sum_scheduler.sv
// Purpose : round-robin share of one descriptor summation pipeline among NUM_REQ requesters, tagged results into a FIFO.
// Latency : transfer T -> oadd_dval T+1 -> iadd_dval T+5 -> ores_valid T+6 (FIFO empty).
// Backpr. : issue is credit-gated on FIFO occupancy + in-flight work, so downstream stalls never reach the adder.
// Ports   : ireq_valid/ireq_data/oreq_ready requester side; oadd_dval/oadd_data and iadd_dval/iadd_sum adder side;
//           ores_valid/ires_ready/ores_sum/ores_id/ores_zero result side; oerr_sync sticky tag mismatch; obusy activity.
module descriptor_sum_scheduler
    import descriptor_sum_scheduler_pkg::*;
#(
    parameter int NUM_REQ     = 2,
    parameter int DESC_ELEMS  = descriptor_sum_scheduler_pkg::DESC_ELEMS,
    parameter int DESC_BITS   = descriptor_sum_scheduler_pkg::DESC_BITS,
    parameter int SUM_W       = descriptor_sum_scheduler_pkg::SUM_W,
    parameter int ADD_LATENCY = descriptor_sum_scheduler_pkg::ADD_LATENCY,
    parameter int FIFO_DEPTH  = 8
) (
    input  logic                                    iclk,
    input  logic                                    ireset,
    input  logic [NUM_REQ-1:0]                      ireq_valid,
    input  logic [NUM_REQ*DESC_ELEMS*DESC_BITS-1:0] ireq_data,
    output logic [NUM_REQ-1:0]                      oreq_ready,
    output logic                                    oadd_dval,
    output logic [DESC_ELEMS*DESC_BITS-1:0]         oadd_data,
    input  logic                                    iadd_dval,
    input  logic [SUM_W-1:0]                        iadd_sum,
    output logic                                    ores_valid,
    input  logic                                    ires_ready,
    output logic [SUM_W-1:0]                        ores_sum,
    output logic [$clog2(NUM_REQ)-1:0]              ores_id,
    output logic                                    ores_zero,
    output logic                                    oerr_sync,
    output logic                                    obusy
);

    localparam int ID_W   = $clog2(NUM_REQ);
    localparam int DESC_W = DESC_ELEMS * DESC_BITS;
    localparam int FCNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int CNT_W  = $clog2(FIFO_DEPTH + ADD_LATENCY + 2) + 1;
    localparam int REC_W  = res_rec_w(ID_W);

    logic [ID_W-1:0]        ptr_q, ptr_d;
    logic                   oadd_dval_q, oadd_dval_d;
    logic [DESC_W-1:0]      oadd_data_q, oadd_data_d;
    logic [ID_W-1:0]        issue_id_q, issue_id_d;
    logic [ADD_LATENCY-1:0] tag_vld_q, tag_vld_d;
    logic [ID_W-1:0]        tag_id_q [ADD_LATENCY];
    logic [ID_W-1:0]        tag_id_d [ADD_LATENCY];
    logic                   err_q, err_d;

    logic                   grant_found;
    logic [ID_W-1:0]        grant_idx;
    logic [ID_W:0]          cand;
    logic [CNT_W-1:0]       inflight;
    logic [CNT_W-1:0]       credit_used;
    logic                   issue_ok;
    logic                   xfer;
    logic [FCNT_W-1:0]      fifo_count;
    logic                   fifo_empty;
    logic [ID_W-1:0]        ret_id;
    logic [REC_W-1:0]       push_rec;
    logic [REC_W-1:0]       head_rec;

    // Round-robin search: first valid requester at or after ptr_q.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = {1'b0, ptr_q} + (ID_W+1)'(i);
            if (cand >= (ID_W+1)'(NUM_REQ)) begin
                cand = cand - (ID_W+1)'(NUM_REQ);
            end
            if (!grant_found && ireq_valid[cand[ID_W-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = cand[ID_W-1:0];
            end
        end
    end

    // Credits: the issue register holds a descriptor that has not yet entered the
    // tag pipe, so it is counted alongside the tag-valid bits to keep the FIFO safe.
    always_comb begin
        inflight = CNT_W'(oadd_dval_q);
        for (int i = 0; i < ADD_LATENCY; i++) begin
            inflight = inflight + CNT_W'(tag_vld_q[i]);
        end
        credit_used = CNT_W'(fifo_count) + inflight;
        issue_ok    = credit_used < CNT_W'(FIFO_DEPTH);
        // Gating with ireset keeps oreq_ready low while reset is held.
        xfer        = grant_found && issue_ok && ireset;
    end

    always_comb begin
        oreq_ready = '0;
        if (xfer) begin
            oreq_ready[grant_idx] = 1'b1;
        end
    end

    always_comb begin
        ptr_d       = ptr_q;
        oadd_dval_d = xfer;
        oadd_data_d = oadd_data_q;
        issue_id_d  = issue_id_q;
        if (xfer) begin
            oadd_data_d = ireq_data[grant_idx*DESC_W +: DESC_W];
            issue_id_d  = grant_idx;
            ptr_d       = (grant_idx == ID_W'(NUM_REQ-1)) ? '0 : grant_idx + 1'b1;
        end
        // Tag stage ADD_LATENCY-1 lines up with the adder's iadd_dval.
        tag_vld_d   = {tag_vld_q[ADD_LATENCY-2:0], oadd_dval_q};
        tag_id_d[0] = issue_id_q;
        for (int i = 1; i < ADD_LATENCY; i++) begin
            tag_id_d[i] = tag_id_q[i-1];
        end
        err_d = err_q | (iadd_dval != tag_vld_q[ADD_LATENCY-1]);
    end

    always_ff @(posedge iclk or negedge ireset) begin
        if (!ireset) begin
            ptr_q       <= '0;
            oadd_dval_q <= 1'b0;
            oadd_data_q <= '0;
            issue_id_q  <= '0;
            tag_vld_q   <= '0;
            for (int i = 0; i < ADD_LATENCY; i++) begin
                tag_id_q[i] <= '0;
            end
            err_q       <= 1'b0;
        end else begin
            ptr_q       <= ptr_d;
            oadd_dval_q <= oadd_dval_d;
            oadd_data_q <= oadd_data_d;
            issue_id_q  <= issue_id_d;
            tag_vld_q   <= tag_vld_d;
            tag_id_q    <= tag_id_d;
            err_q       <= err_d;
        end
    end

    // A result with no matching tag is still recorded, attributed to requester 0.
    assign ret_id   = tag_vld_q[ADD_LATENCY-1] ? tag_id_q[ADD_LATENCY-1] : '0;
    assign push_rec = {ret_id, iadd_sum, (iadd_sum == '0)};

    sum_result_fifo #(
        .WIDTH (REC_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .iclk   (iclk),
        .ireset (ireset),
        .ipush  (iadd_dval),
        .idata  (push_rec),
        .ipop   (ores_valid && ires_ready),
        .odata  (head_rec),
        .oempty (fifo_empty),
        .ocount (fifo_count)
    );

    assign ores_valid = !fifo_empty;
    assign {ores_id, ores_sum, ores_zero} = head_rec;
    assign oadd_dval  = oadd_dval_q;
    assign oadd_data  = oadd_data_q;
    assign oerr_sync  = err_q;
    assign obusy      = (|tag_vld_q) | oadd_dval_q | !fifo_empty;

endmodule
